seq_alu_unit: RTL and testbench

- Registered, parametrised successor to the combinational n-bit ALU datapath.
- Keeps the same add/sub/logic function set and adds shifts/rotates, add/subtract with the stored carry, and a multi-cycle unsigned shift-add multiply.
- Uses a start/busy/done handshake and registered N/Z/C/V flags.
- Sits between the register file and the writeback stage of the processor datapath.

---
 rtl/seq_alu_unit.sv | 186 ++++++++++++++++++
 tb/tb_seq_alu_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit.sv
// Registered ALU: single-cycle add/sub/logic/shift ops plus a multi-cycle
// unsigned shift-add multiply, with registered N/Z/C/V flags.
module seq_alu_unit #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         mod,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] f,
    output logic [N-1:0] f_hi,
    output logic         busy,
    output logic         done,
    output logic         flag_c,
    output logic         flag_v,
    output logic         flag_z,
    output logic         flag_n
);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SH  = 3'b100;
    localparam logic [2:0] OP_ROT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(N);

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  a_q;
    logic [N-1:0]  hi_q;
    logic [N-1:0]  lo_q;
    logic [CW-1:0] cnt_q;

    logic          sc_go;
    logic          mul_go;
    logic          mul_step;
    logic          mul_last;

    logic [N-1:0]  y;
    logic          cin;
    logic [N:0]    sum;
    logic          c_msb;
    logic [N-1:0]  alu_f;
    logic          alu_c;
    logic          alu_v;
    logic [N:0]    mul_sum;

    // Adder shared by ADD/SUB and ADC/SBC; ADC reads the registered carry.
    always_comb begin
        y     = mod ? ~b : b;
        cin   = (op == OP_ADC) ? flag_c : mod;
        sum   = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, cin};
        c_msb = a[N-1] ^ y[N-1] ^ sum[N-1];
    end

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                alu_f = sum[N-1:0];
                alu_c = sum[N];
                alu_v = c_msb ^ sum[N];
            end
            OP_OR:  alu_f = mod ? (a | ~b) : (a | b);
            OP_AND: alu_f = mod ? (a & ~b) : (a & b);
            OP_NOT: alu_f = mod ? ~b : ~a;
            OP_SH: begin
                alu_f = mod ? {1'b0, a[N-1:1]} : {a[N-2:0], 1'b0};
                alu_c = mod ? a[0] : a[N-1];
            end
            OP_ROT: begin
                alu_f = mod ? {a[0], a[N-1:1]} : {a[N-2:0], a[N-1]};
                alu_c = mod ? a[0] : a[N-1];
            end
            default: ;
        endcase
    end

    // Keep the adder carry: the max product needs the (N+1)th bit.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    end

    always_comb begin
        state_d  = state_q;
        sc_go    = 1'b0;
        mul_go   = 1'b0;
        mul_step = 1'b0;
        mul_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_go  = 1'b1;
                        state_d = S_MUL;
                    end else begin
                        sc_go = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_END) begin
                    mul_last = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    mul_step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            f      <= '0;
            f_hi   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sc_go) begin
                f      <= alu_f;
                f_hi   <= '0;
                flag_c <= alu_c;
                flag_v <= alu_v;
                flag_z <= (alu_f == '0);
                flag_n <= alu_f[N-1];
                done   <= 1'b1;
            end else if (mul_go) begin
                a_q   <= a;
                hi_q  <= '0;
                lo_q  <= b;
                cnt_q <= '0;
                busy  <= 1'b1;
            end else if (mul_step) begin
                hi_q  <= mul_sum[N:1];
                lo_q  <= {mul_sum[0], lo_q[N-1:1]};
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    busy <= 1'b0;
                end
            end else if (mul_last) begin
                f      <= lo_q;
                f_hi   <= hi_q;
                flag_c <= (hi_q != '0);
                flag_v <= 1'b0;
                flag_z <= ({hi_q, lo_q} == '0);
                flag_n <= hi_q[N-1];
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Scoreboard bench for seq_alu_unit: expected results queued at issue,
// compared on each done pulse, plus latency, busy and reset checks.
module tb_seq_alu_unit;

    localparam int N  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [7:0] f;
        logic [7:0] fh;
        logic [3:0] fl;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         mod;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] f;
    logic [N-1:0] f_hi;
    logic         busy;
    logic         done;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_n;

    exp_t sb[$];
    logic mc;
    int   n_tests;
    int   n_fail;

    seq_alu_unit #(.N(N), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .mod    (mod),
        .a      (a),
        .b      (b),
        .f      (f),
        .f_hi   (f_hi),
        .busy   (busy),
        .done   (done),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .flag_z (flag_z),
        .flag_n (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic md,
                                   input logic [7:0] x, input logic [7:0] y,
                                   input logic ci);
        exp_t e;
        logic [15:0] p;
        logic [7:0] yy;
        int s;
        logic c, v, z, n;
        e.f  = '0;
        e.fh = '0;
        p = '0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0, 3'd7: begin
                yy = md ? ~y : y;
                s = int'(x) + int'(yy) + ((o == 3'd0) ? int'(md) : int'(ci));
                e.f = s[7:0];
                c = (s > 255);
                v = (x[7] == yy[7]) && (e.f[7] != x[7]);
            end
            3'd1: e.f = md ? (x | ~y) : (x | y);
            3'd2: e.f = md ? (x & ~y) : (x & y);
            3'd3: e.f = md ? ~y : ~x;
            3'd4: begin
                e.f = md ? (x >> 1) : (x << 1);
                c = md ? x[0] : x[7];
            end
            3'd5: begin
                e.f = md ? {x[0], x[7:1]} : {x[6:0], x[7]};
                c = md ? x[0] : x[7];
            end
            default: begin
                p = {8'h00, x} * {8'h00, y};
                e.f  = p[7:0];
                e.fh = p[15:8];
                c = (p[15:8] != 8'h00);
            end
        endcase
        z = (o == 3'd6) ? (p == 16'h0) : (e.f == 8'h00);
        n = (o == 3'd6) ? e.fh[7] : e.f[7];
        e.fl = {c, v, z, n};
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic md,
                         input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        @(negedge clk);
        op = o;
        mod = md;
        a = x;
        b = y;
        start = 1'b1;
        e = model(o, md, x, y, mc);
        mc = e.fl[3];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic mul_run(input logic [7:0] x, input logic [7:0] y,
                           input logic poke, output int lat, output int bcnt);
        issue(3'd6, 1'b0, x, y);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            if (poke && lat == 3) begin
                op = 3'd0;
                a = 8'h11;
                b = 8'h22;
                start = 1'b1;
            end
            if (lat == 4) start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexp_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("f", 32'(f), 32'(e.f));
                check("f_hi", 32'(f_hi), 32'(e.fh));
                check("cvzn", 32'({flag_c, flag_v, flag_z, flag_n}),
                      32'(e.fl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int bcnt;
        logic [2:0] r;
        n_tests = 0;
        n_fail = 0;
        mc = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        op = '0;
        mod = 1'b0;
        a = '0;
        b = '0;
        #2;
        check("rst_out", 32'({f, f_hi, busy, done, flag_c, flag_v,
                              flag_z, flag_n}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'd0, 1'b0, 8'h7F, 8'h01);
        issue(3'd0, 1'b1, 8'h05, 8'h05);
        issue(3'd7, 1'b0, 8'h01, 8'h01);
        issue(3'd4, 1'b0, 8'h81, 8'h00);
        issue(3'd5, 1'b1, 8'h01, 8'h00);
        idle(2);
        check("sc_busy", 32'(busy), 32'(0));

        mul_run(8'hFF, 8'hFF, 1'b1, lat, bcnt);
        check("mul_lat", 32'(lat), 32'(9));
        check("mul_busy", 32'(bcnt), 32'(8));
        idle(3);

        mul_run(8'h00, 8'h37, 1'b0, lat, bcnt);
        check("mul0_lat", 32'(lat), 32'(9));
        idle(2);

        issue(3'd6, 1'b0, 8'hAB, 8'hCD);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid", 32'({f, f_hi, busy, done, flag_c, flag_v,
                              flag_z, flag_n}), 32'(0));
        sb.delete();
        mc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", 32'({busy, done}), 32'(0));

        issue(3'd2, 1'b0, 8'hF0, 8'h3C);
        issue(3'd7, 1'b0, 8'h01, 8'h01);
        idle(1);
        a = 8'h55;
        b = 8'hAA;
        op = 3'd1;
        repeat (3) @(negedge clk);
        check("hold_f", 32'(f), 32'(8'h02));

        for (int i = 0; i < 30; i++) begin
            r = 3'($urandom_range(0, 6));
            if (r == 3'd6) r = 3'd7;
            issue(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end
        idle(2);

        for (int i = 0; i < 4; i++) begin
            mul_run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'b0, lat, bcnt);
            check("rmul_lat", 32'(lat), 32'(9));
            idle(1);
        end
        issue(3'd7, 1'b1, 8'h10, 8'h03);
        idle(3);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
